// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the serial RGB word assembler.
//   state_t  - assembler FSM states
//   WORD_W   - bits per serial pixel word (G, R, B)
//   COMP_W   - bits per colour component
//   min3()   - smallest of three components (white extraction)
package rgb_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      COLLECT   = 2'd1,
      DISCARD   = 2'd2
   } state_t;

   localparam int WORD_W = 24;
   localparam int COMP_W = 8;

   function automatic logic [COMP_W-1:0] min3(input logic [COMP_W-1:0] a,
                                               input logic [COMP_W-1:0] b,
                                               input logic [COMP_W-1:0] c);
      logic [COMP_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

endpackage

// File: rtl/rgb_pix_fifo.sv
// rgb_pix_fifo: synchronous FIFO with simultaneous push and pop.
//   clk, rst     - clock, synchronous active-high reset
//   push, din    - write request and data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   pop          - read request; ignored when empty
//   dout         - head entry (valid while empty=0)
//   full, empty  - occupancy flags
module rgb_pix_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/rgb_word_asm.sv
// rgb_word_asm: assembles serial bits into 24-bit G,R,B pixels and buffers
// them with their in-frame index.
//   clk, rst                  - clock, synchronous active-high reset
//   bit_in, bit_strobe        - serial data bit and its one-cycle strobe
//   stream_reset              - with bit_strobe: end-of-frame gap
//   pix_g/r/b/w, pix_index    - head pixel (all zero while pix_valid=0)
//   pix_valid, pix_ready      - output handshake
//   frame_done                - one-cycle pulse when a non-empty frame ends
//   overflow                  - sticky: a completed pixel found the FIFO full
// Build option: RGBW_CONV_EN extracts W=min(R,G,B) before buffering;
// otherwise pix_w is 0 and G,R,B pass through.
module rgb_word_asm
   import rgb_pkg::*;
#(
   parameter int MAX_PIXELS = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          bit_in,
   input  logic                          bit_strobe,
   input  logic                          stream_reset,
   output logic [COMP_W-1:0]             pix_g,
   output logic [COMP_W-1:0]             pix_r,
   output logic [COMP_W-1:0]             pix_b,
   output logic [COMP_W-1:0]             pix_w,
   output logic [$clog2(MAX_PIXELS)-1:0] pix_index,
   output logic                          pix_valid,
   input  logic                          pix_ready,
   output logic                          frame_done,
   output logic                          overflow
);
   localparam int IDX_W = $clog2(MAX_PIXELS);
   localparam int CNT_W = $clog2(MAX_PIXELS + 1);
   localparam int ENT_W = IDX_W + 4*COMP_W;

   state_t              state, state_next;
   logic [WORD_W-2:0]   shreg;
   logic [4:0]          bit_cnt;
   logic [CNT_W-1:0]    pix_cnt;
   logic                data_stb, sync_stb, word_done;
   logic                shift_en, push_req, fd_next;
   logic [WORD_W-1:0]   word;
   logic [COMP_W-1:0]   g, r, b, cg, cr, cb, cw;
   logic [ENT_W-1:0]    din, dout;
   logic                full, empty, pop;

   assign data_stb  = bit_strobe & ~stream_reset;
   assign sync_stb  = bit_strobe & stream_reset;
   assign word_done = (state == COLLECT) && data_stb && (bit_cnt == 5'd23);

   // Completed word includes the bit arriving on the completing strobe.
   assign word = {shreg, bit_in};
   assign g    = word[23:16];
   assign r    = word[15:8];
   assign b    = word[7:0];

`ifdef RGBW_CONV_EN
   assign cw = min3(g, r, b);
   assign cg = g - cw;
   assign cr = r - cw;
   assign cb = b - cw;
`else
   assign cw = '0;
   assign cg = g;
   assign cr = r;
   assign cb = b;
`endif

   // pix_cnt < MAX_PIXELS whenever a word completes, so truncation is exact.
   assign din = {pix_cnt[IDX_W-1:0], cg, cr, cb, cw};

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_SYNC;
      else     state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         WAIT_SYNC: if (sync_stb) state_next = COLLECT;
         COLLECT: begin
            if (sync_stb)
               state_next = COLLECT;
            else if (word_done && pix_cnt == CNT_W'(MAX_PIXELS - 1))
               state_next = DISCARD;
         end
         DISCARD:   if (sync_stb) state_next = COLLECT;
         default:   state_next = WAIT_SYNC;
      endcase
   end

   // FSM: outputs
   always_comb begin
      shift_en = (state == COLLECT) && data_stb;
      push_req = word_done;
      fd_next  = sync_stb && (state != WAIT_SYNC) && (pix_cnt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= fd_next;
         if (push_req && full && !pop) overflow <= 1'b1;
         if (sync_stb) begin
            shreg   <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
         end else if (shift_en) begin
            shreg   <= {shreg[WORD_W-3:0], bit_in};
            bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
            if (word_done) pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

   rgb_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (din),
      .pop   (pop),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   assign pix_valid = ~empty;
   assign pop       = pix_valid & pix_ready;

   // Gate head data so outputs read zero whenever nothing is buffered.
   always_comb begin
      {pix_index, pix_g, pix_r, pix_b, pix_w} = pix_valid ? dout : '0;
   end

endmodule

// File: tb/tb_rgb_word_asm.sv
// tb_rgb_word_asm: directed bench for rgb_word_asm. Instance dut uses the
// default parameters; dut2 uses MAX_PIXELS=2 for the frame-limit case.
module tb_rgb_word_asm;
   import rgb_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0, bit_strobe = 1'b0, stream_reset = 1'b0;
   logic       pix_ready = 1'b0, pix_ready2 = 1'b1;

   logic [7:0] pix_g, pix_r, pix_b, pix_w, pix_index;
   logic       pix_valid, frame_done, overflow;
   logic [7:0] g2, r2, b2, w2;
   logic [0:0] idx2;
   logic       valid2, fd2, ovf2;

   int total = 0, bad = 0;
   int fd_cnt = 0, fd2_cnt = 0;
   int snap, snap2;

   always #5 clk = ~clk;

   rgb_word_asm dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
      .stream_reset(stream_reset), .pix_g(pix_g), .pix_r(pix_r),
      .pix_b(pix_b), .pix_w(pix_w), .pix_index(pix_index),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .frame_done(frame_done), .overflow(overflow)
   );

   rgb_word_asm #(.MAX_PIXELS(2)) dut2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
      .stream_reset(stream_reset), .pix_g(g2), .pix_r(r2),
      .pix_b(b2), .pix_w(w2), .pix_index(idx2),
      .pix_valid(valid2), .pix_ready(pix_ready2),
      .frame_done(fd2), .overflow(ovf2)
   );

   always @(posedge clk) begin
      if (frame_done) fd_cnt  <= fd_cnt + 1;
      if (fd2)        fd2_cnt <= fd2_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1; bit_strobe = 1'b0; stream_reset = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_in = b; bit_strobe = 1'b1; stream_reset = 1'b0;
      @(negedge clk);
      bit_strobe = 1'b0;
   endtask

   task automatic send_sync();
      @(negedge clk);
      bit_strobe = 1'b1; stream_reset = 1'b1;
      @(negedge clk);
      bit_strobe = 1'b0; stream_reset = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] eg, input logic [7:0] ei);
      chk({tag, "_v"}, 32'(pix_valid), 32'd1);
      chk({tag, "_g"}, 32'(pix_g), 32'(eg));
      chk({tag, "_i"}, 32'(pix_index), 32'(ei));
      pix_ready = 1'b1;
      @(negedge clk);
      pix_ready = 1'b0;
   endtask

   task automatic pop2_chk(input string tag, input logic [7:0] eg, input logic ei);
      chk({tag, "_v"}, 32'(valid2), 32'd1);
      chk({tag, "_g"}, 32'(g2), 32'(eg));
      chk({tag, "_i"}, 32'(idx2), 32'(ei));
      pix_ready2 = 1'b1;
      @(negedge clk);
      pix_ready2 = 1'b0;
   endtask

   initial begin
      logic [23:0] w;

      // reset state
      do_rst();
      chk("rst_valid", 32'(pix_valid), 0);
      chk("rst_g", 32'(pix_g), 0);
      chk("rst_r", 32'(pix_r), 0);
      chk("rst_b", 32'(pix_b), 0);
      chk("rst_w", 32'(pix_w), 0);
      chk("rst_idx", 32'(pix_index), 0);
      chk("rst_fd", 32'(frame_done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_state", 32'(dut.state), 32'(WAIT_SYNC));

      // data before any sync is ignored
      send_word(24'hABCDEF);
      chk("presync_valid", 32'(pix_valid), 0);
      chk("presync_state", 32'(dut.state), 32'(WAIT_SYNC));

      // basic pixel, latency of one cycle after completing strobe
      do_rst();
      snap = fd_cnt;
      send_sync();
      w = 24'hFF8040;
      for (int i = 23; i >= 1; i--) send_bit(w[i]);
      @(negedge clk);
      bit_in = w[0]; bit_strobe = 1'b1;
      chk("basic_early", 32'(pix_valid), 0);
      @(negedge clk);
      bit_strobe = 1'b0;
      chk("basic_valid", 32'(pix_valid), 1);
`ifdef RGBW_CONV_EN
      chk("basic_g", 32'(pix_g), 32'h BF);
      chk("basic_r", 32'(pix_r), 32'h40);
      chk("basic_b", 32'(pix_b), 32'h00);
      chk("basic_w", 32'(pix_w), 32'h40);
`else
      chk("basic_g", 32'(pix_g), 32'hFF);
      chk("basic_r", 32'(pix_r), 32'h80);
      chk("basic_b", 32'(pix_b), 32'h40);
      chk("basic_w", 32'(pix_w), 32'h00);
`endif
      chk("basic_idx", 32'(pix_index), 0);
      chk("basic_nofd", 32'(fd_cnt - snap), 0);

      // partial word dropped by sync, no frame_done
      do_rst();
      send_sync();
      snap = fd_cnt;
      for (int i = 0; i < 12; i++) send_bit(1'b1);
      send_sync();
      @(negedge clk);
      chk("partial_nofd", 32'(fd_cnt - snap), 0);
      send_word(24'h000001);
      chk("partial_b", 32'(pix_b), 32'h01);
      chk("partial_r", 32'(pix_r), 0);
      pop_chk("partial", 8'h00, 8'd0);
      chk("partial_single", 32'(pix_valid), 0);

      // overflow: 5 pixels into depth-4 FIFO with no reads
      do_rst();
      send_sync();
      for (int i = 0; i < 5; i++) begin
         send_word({8'h10 + 8'(i), 16'h0000});
         if (i == 3) chk("ovf_pre", 32'(overflow), 0);
      end
      chk("ovf_set", 32'(overflow), 1);
      for (int i = 0; i < 4; i++) pop_chk("ovf_pop", 8'h10 + 8'(i), 8'(i));
      chk("ovf_empty", 32'(pix_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);
      do_rst();
      chk("ovf_clr", 32'(overflow), 0);

      // full FIFO with a pop on the completing cycle accepts the push
      send_sync();
      for (int i = 0; i < 4; i++) send_word({8'h10 + 8'(i), 16'h0000});
      w = 24'h140000;
      for (int i = 23; i >= 1; i--) send_bit(w[i]);
      @(negedge clk);
      bit_in = w[0]; bit_strobe = 1'b1; pix_ready = 1'b1;
      @(negedge clk);
      bit_strobe = 1'b0; pix_ready = 1'b0;
      chk("fullpop_ovf", 32'(overflow), 0);
      for (int i = 1; i < 5; i++) pop_chk("fullpop", 8'h10 + 8'(i), 8'(i));
      chk("fullpop_empty", 32'(pix_valid), 0);

      // frame limit on MAX_PIXELS=2 instance
      do_rst();
      pix_ready2 = 1'b0;
      send_sync();
      snap2 = fd2_cnt;
      for (int i = 0; i < 3; i++) send_word({8'h20 + 8'(i), 16'h0000});
      send_sync();
      @(negedge clk);
      chk("max_fd", 32'(fd2_cnt - snap2), 1);
      chk("max_ovf", 32'(ovf2), 0);
      pop2_chk("max_pop0", 8'h20, 1'b0);
      pop2_chk("max_pop1", 8'h21, 1'b1);
      chk("max_empty", 32'(valid2), 0);
      pix_ready2 = 1'b1;

      // reset mid-frame: no frame_done, pending data gone
      do_rst();
      send_sync();
      send_word(24'h123456);
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      snap = fd_cnt;
      do_rst();
      @(negedge clk);
      chk("midrst_fd", 32'(fd_cnt - snap), 0);
      chk("midrst_valid", 32'(pix_valid), 0);
      chk("midrst_state", 32'(dut.state), 32'(WAIT_SYNC));
      send_sync();
      @(negedge clk);
      chk("midrst_sync_fd", 32'(fd_cnt - snap), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
